// File: rtl/cache_pkg.sv
// Shared types and constants for the IC/DC memory-port arbiter.
package cache_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam logic CLI_IC = 1'b0;
  localparam logic CLI_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: a lone requester always wins; on a tie the
// pointer decides in round-robin mode, otherwise DC wins.
module arb_pick2
  import cache_pkg::*;
(
  input  logic req_ic_i,
  input  logic req_dc_i,
  input  logic ptr_i,
  input  logic rr_mode_i,
  output logic winner_o
);

  always_comb begin
    winner_o = CLI_IC;
    if (req_ic_i && req_dc_i) begin
      winner_o = rr_mode_i ? ptr_i : CLI_DC;
    end else if (req_dc_i) begin
      winner_o = CLI_DC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one block-memory port between IC and DC; grant held until mem_ready.
// ARB_RR_EN selects round-robin tie-break, otherwise DC has fixed priority.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,

  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [DATA_W-1:0] ic_mem_wdata,
  output logic              ic_mem_ready,
  output logic [DATA_W-1:0] ic_mem_rdata,

  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic              dc_mem_ready,
  output logic [DATA_W-1:0] dc_mem_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              arb_busy,
  output logic              arb_owner
);

  arb_state_t state_q, state_d;
  logic       req_ic, req_dc;
  logic       winner;
  logic       ptr_cur;
  logic       rr_mode;
  logic       grant_now;

  assign req_ic    = ic_mem_read | ic_mem_write;
  assign req_dc    = dc_mem_read | dc_mem_write;
  assign grant_now = (state_q == IDLE) && (req_ic || req_dc);

`ifdef ARB_RR_EN
  logic ptr_q, ptr_d;

  assign rr_mode = 1'b1;
  assign ptr_cur = ptr_q;

  // Every grant, contested or not, hands preference to the other client.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_now) ptr_d = ~winner;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) ptr_q <= CLI_IC;
    else            ptr_q <= ptr_d;
  end
`else
  assign rr_mode = 1'b0;
  assign ptr_cur = CLI_IC;
`endif

  arb_pick2 u_pick (
    .req_ic_i  (req_ic),
    .req_dc_i  (req_dc),
    .ptr_i     (ptr_cur),
    .rr_mode_i (rr_mode),
    .winner_o  (winner)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Write wins over read when a client raises both.
  always_comb begin
    state_d      = state_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_mem_ready = 1'b0;
    dc_mem_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_now) state_d = (winner == CLI_DC) ? GNT_DC : GNT_IC;
      end
      GNT_IC: begin
        mem_read     = ic_mem_read & ~ic_mem_write;
        mem_write    = ic_mem_write;
        mem_addr     = ic_mem_addr;
        mem_wdata    = ic_mem_wdata;
        ic_mem_ready = mem_ready;
        if (mem_ready) state_d = IDLE;
      end
      GNT_DC: begin
        mem_read     = dc_mem_read & ~dc_mem_write;
        mem_write    = dc_mem_write;
        mem_addr     = dc_mem_addr;
        mem_wdata    = dc_mem_wdata;
        dc_mem_ready = mem_ready;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;
  assign arb_busy     = (state_q != IDLE);
  assign arb_owner    = (state_q == GNT_DC);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected completions are queued by
// the stimulus thread and checked by a monitor on each client ready pulse.
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          ic_mem_read, ic_mem_write, ic_mem_ready;
  logic [AW-1:0] ic_mem_addr;
  logic [DW-1:0] ic_mem_wdata, ic_mem_rdata;
  logic          dc_mem_read, dc_mem_write, dc_mem_ready;
  logic [AW-1:0] dc_mem_addr;
  logic [DW-1:0] dc_mem_wdata, dc_mem_rdata;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          arb_busy, arb_owner;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_write (ic_mem_write),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_wdata (ic_mem_wdata),
    .ic_mem_ready (ic_mem_ready),
    .ic_mem_rdata (ic_mem_rdata),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_ready (dc_mem_ready),
    .dc_mem_rdata (dc_mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .arb_busy     (arb_busy),
    .arb_owner    (arb_owner)
  );

  typedef struct {
    logic          owner;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  logic mem_en = 1'b1;
  int   stray_cnt = 0;

  function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
    if (a == 28'h0000010) return 128'hDEAD0000_00000000_00000000_0000BEEF;
    return {4{4'hA, a}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic owner, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.owner = owner; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Callers start at posedge+1; the task returns at posedge+1 with the request dropped.
  task automatic ic_op(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n;
    ic_mem_read = rd; ic_mem_write = wr; ic_mem_addr = a; ic_mem_wdata = wd;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ic_mem_ready) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL ic_timeout addr=%0h actual=no_ready required=ready", a);
    end
    @(posedge clk); #1;
    ic_mem_read = 1'b0; ic_mem_write = 1'b0;
  endtask

  task automatic dc_op(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n;
    dc_mem_read = rd; dc_mem_write = wr; dc_mem_addr = a; dc_mem_wdata = wd;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dc_mem_ready) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL dc_timeout addr=%0h actual=no_ready required=ready", a);
    end
    @(posedge clk); #1;
    dc_mem_read = 1'b0; dc_mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    proc_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    proc_reset = 1'b0;
  endtask

  // Memory model: ready after mem_lat cycles of a visible request, or a stray pulse on demand.
  initial begin
    int cnt;
    int stray_seen;
    cnt = 0; stray_seen = 0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        mem_ready  = 1'b1;
        mem_rdata  = '1;
        cnt        = 0;
      end else if ((mem_read || mem_write) && mem_en) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = blk(mem_addr);
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ic_mem_ready || dc_mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready actual ic=%0b dc=%0b required=none", ic_mem_ready, dc_mem_ready);
        end else begin
          e = exp_q.pop_front();
          chk("ready_with_mem_ready", mem_ready, 1'b1);
          chk("owner", arb_owner, e.owner);
          chk("ic_ready", ic_mem_ready, e.owner == CLI_IC);
          chk("dc_ready", dc_mem_ready, e.owner == CLI_DC);
          chk("mem_write", mem_write, e.wr);
          chk("mem_read", mem_read, !e.wr);
          chk("mem_addr", mem_addr, e.addr);
          if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
          else      chk("rdata", e.owner ? dc_mem_rdata : ic_mem_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a_ic, a_dc;
    proc_reset = 1'b1;
    ic_mem_read = 0; ic_mem_write = 0; ic_mem_addr = '0; ic_mem_wdata = '0;
    dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_ic_ready", ic_mem_ready, 1'b0);
    chk("rst_dc_ready", dc_mem_ready, 1'b0);
    @(posedge clk); #1;
    proc_reset = 1'b0;

    // Single IC read with 3-cycle memory latency and one bubble cycle.
    mem_lat = 3;
    push(CLI_IC, 1'b0, 28'h0000010, '0, 128'hDEAD0000_00000000_00000000_0000BEEF);
    fork
      ic_op(1'b1, 1'b0, 28'h0000010, '0);
      begin
        @(negedge clk);
        chk("bubble_busy", arb_busy, 1'b0);
        chk("bubble_mem_read", mem_read, 1'b0);
        @(negedge clk);
        chk("grant_busy", arb_busy, 1'b1);
        chk("grant_mem_read", mem_read, 1'b1);
        chk("grant_mem_addr", mem_addr, 28'h0000010);
        chk("grant_owner", arb_owner, CLI_IC);
      end
    join

    // Simultaneous requests, three rounds.
    do_reset();
    mem_lat = 1;
    for (int r = 0; r < 3; r++) begin
      a_ic = 28'h0000100 + AW'(r);
      a_dc = 28'h0000200 + AW'(r);
`ifdef ARB_RR_EN
      push(CLI_IC, 1'b0, a_ic, '0, blk(a_ic));
      push(CLI_DC, 1'b0, a_dc, '0, blk(a_dc));
`else
      push(CLI_DC, 1'b0, a_dc, '0, blk(a_dc));
      push(CLI_IC, 1'b0, a_ic, '0, blk(a_ic));
`endif
      fork
        ic_op(1'b1, 1'b0, a_ic, '0);
        dc_op(1'b1, 1'b0, a_dc, '0);
      join
    end

`ifdef ARB_RR_EN
    // Continuous requesting from both clients alternates starting with IC.
    do_reset();
    push(CLI_IC, 1'b0, 28'h0000500, '0, blk(28'h0000500));
    push(CLI_DC, 1'b0, 28'h0000600, '0, blk(28'h0000600));
    push(CLI_IC, 1'b0, 28'h0000501, '0, blk(28'h0000501));
    push(CLI_DC, 1'b0, 28'h0000601, '0, blk(28'h0000601));
    fork
      begin ic_op(1'b1, 1'b0, 28'h0000500, '0); ic_op(1'b1, 1'b0, 28'h0000501, '0); end
      begin dc_op(1'b1, 1'b0, 28'h0000600, '0); dc_op(1'b1, 1'b0, 28'h0000601, '0); end
    join
`endif

    // DC write-back then refill, IC arriving during the write-back.
    do_reset();
    mem_lat = 2;
    push(CLI_DC, 1'b1, 28'h0000700, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, '0);
`ifdef ARB_RR_EN
    push(CLI_IC, 1'b0, 28'h0000710, '0, blk(28'h0000710));
    push(CLI_DC, 1'b0, 28'h0000701, '0, blk(28'h0000701));
`else
    push(CLI_DC, 1'b0, 28'h0000701, '0, blk(28'h0000701));
    push(CLI_IC, 1'b0, 28'h0000710, '0, blk(28'h0000710));
`endif
    fork
      begin
        dc_op(1'b0, 1'b1, 28'h0000700, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        dc_op(1'b1, 1'b0, 28'h0000701, '0);
      end
      begin
        @(posedge clk); #1;
        ic_op(1'b1, 1'b0, 28'h0000710, '0);
      end
    join

    // DC read+write together, then a stray mem_ready while idle.
    mem_lat = 1;
    push(CLI_DC, 1'b1, 28'h0000800, 128'hCAFEF00D_00000000_11111111_22222222, '0);
    dc_op(1'b1, 1'b1, 28'h0000800, 128'hCAFEF00D_00000000_11111111_22222222);
    stray_cnt++;
    @(negedge clk);
    chk("stray_busy", arb_busy, 1'b0);
    chk("stray_ic_ready", ic_mem_ready, 1'b0);
    chk("stray_dc_ready", dc_mem_ready, 1'b0);

    // Reset in the middle of a DC grant.
    @(posedge clk); #1;
    mem_en = 1'b0;
    dc_mem_read = 1'b1; dc_mem_write = 1'b0; dc_mem_addr = 28'h0000900;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", arb_busy, 1'b1);
    chk("pre_rst_owner", arb_owner, CLI_DC);
    chk("pre_rst_mem_read", mem_read, 1'b1);
    @(posedge clk); #1;
    proc_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_busy", arb_busy, 1'b0);
    @(posedge clk); #1;
    proc_reset = 1'b0;
    dc_mem_read = 1'b0;
    mem_en = 1'b1;
    stray_cnt++;
    @(negedge clk);
    chk("post_rst_dc_ready", dc_mem_ready, 1'b0);
    chk("post_rst_busy", arb_busy, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
